apb2axi_apb_frontend: RTL and testbench

APB3 slave front-end of the APB-to-AXI bridge; consumes the APB bus (master drives PADDR/PWRITE/PWDATA/PSEL/PENABLE) and produces PRDATA/PREADY/PSLVERR.
- Decodes a small register map. Downstream it emits AXI request descriptors and write-data beats, and consumes read-data beats, over valid/ready handshakes to the bridge core.
- Inserts APB wait states while a downstream handshake is pending; reports PSLVERR on decode error, response error or timeout.

---
 rtl/apb2axi_pkg.sv | 77 +++++++
 rtl/apb2axi_timeout_cnt.sv | 39 +++
 rtl/apb2axi_apb_frontend.sv | 243 ++++++++++++++++++++++++
 tb/tb_apb2axi_apb_frontend.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge front-end.
package apb2axi_pkg;

    // Register offsets within the 32-byte APB window (PADDR[4:0])
    localparam logic [4:0] REG_ADDR   = 5'h00;
    localparam logic [4:0] REG_CTRL   = 5'h04;
    localparam logic [4:0] REG_CMD    = 5'h08;
    localparam logic [4:0] REG_WDATA  = 5'h0C;
    localparam logic [4:0] REG_RDATA  = 5'h10;
    localparam logic [4:0] REG_STATUS = 5'h14;

    // Storage width of the descriptor address field; the top narrows it to AXI_ADDR_WIDTH
    localparam int unsigned REQ_ADDR_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT_REQ,
        ST_WAIT_WD,
        ST_WAIT_RD,
        ST_DONE
    } apb_state_e;

    typedef enum logic [2:0] {
        SEL_ADDR,
        SEL_CTRL,
        SEL_CMD,
        SEL_WDATA,
        SEL_RDATA,
        SEL_STATUS,
        SEL_NONE
    } reg_sel_e;

    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [7:0] len;
    } ctrl_reg_t;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic                  write;
        logic [3:0]            tag;
    } req_desc_t;

    // Map a word offset onto a register; misaligned or unmapped offsets give SEL_NONE
    function automatic reg_sel_e decode_reg(input logic [4:0] off);
        case (off)
            REG_ADDR:   return SEL_ADDR;
            REG_CTRL:   return SEL_CTRL;
            REG_CMD:    return SEL_CMD;
            REG_WDATA:  return SEL_WDATA;
            REG_RDATA:  return SEL_RDATA;
            REG_STATUS: return SEL_STATUS;
            default:    return SEL_NONE;
        endcase
    endfunction

    // Direction legality: CMD/WDATA are write-only, RDATA/STATUS read-only
    function automatic logic access_ok(input reg_sel_e sel, input logic wr);
        case (sel)
            SEL_ADDR, SEL_CTRL:    return 1'b1;
            SEL_CMD, SEL_WDATA:    return wr;
            SEL_RDATA, SEL_STATUS: return !wr;
            default:               return 1'b0;
        endcase
    endfunction

    // STATUS layout: [0] req_valid, [1] rd_valid, [2] wd_valid, [15:8] err_count
    function automatic logic [15:0] status_word(input logic req_v, input logic rd_v,
                                                input logic wd_v, input logic [7:0] errc);
        return {errc, 5'b0, wd_v, rd_v, req_v};
    endfunction

endpackage

// File: rtl/apb2axi_timeout_cnt.sv
// Wait-state timeout counter: cleared while idle, counts while enabled,
// flags expiry on the TIMEOUT_CYC-th enabled cycle.
module apb2axi_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Next count: clear has priority, hold once expired
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb2axi_apb_frontend.sv
// APB3 slave front-end of the APB-to-AXI bridge: register map, request
// descriptor / write-beat / read-beat handshakes, wait states and timeout.
module apb2axi_apb_frontend
    import apb2axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYC    = 256
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic                      PWRITE,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [AXI_ADDR_WIDTH-1:0] req_addr,
    output logic [7:0]                req_len,
    output logic [2:0]                req_size,
    output logic                      req_write,
    output logic [3:0]                req_tag,
    output logic                      wd_valid,
    input  logic                      wd_ready,
    output logic [DATA_WIDTH-1:0]     wd_data,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      rd_err
);

    apb_state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic                      req_valid_q, req_valid_d;
    req_desc_t                 req_q, req_d;
    logic                      wd_valid_q, wd_valid_d;
    logic [DATA_WIDTH-1:0]     wd_data_q, wd_data_d;
    logic                      rd_ready_q, rd_ready_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    ctrl_reg_t                 ctrl_q, ctrl_d;
    logic [7:0]                err_count_q, err_count_d;

    reg_sel_e reg_sel;
    logic     acc_ok;
    logic     setup;
    logic     in_wait;
    logic     tmo_expired;

    // Only PADDR[4:0] takes part in decode; the upper address bits alias
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^PADDR[ADDR_WIDTH-1:5];

    assign reg_sel = decode_reg(PADDR[4:0]);
    assign acc_ok  = access_ok(reg_sel, PWRITE);
    assign setup   = PSEL && !PENABLE;
    assign in_wait = (state_q == ST_WAIT_REQ) || (state_q == ST_WAIT_WD) ||
                     (state_q == ST_WAIT_RD);

    apb2axi_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (PCLK),
        .rst     (PRESET),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (tmo_expired)
    );

    // Next-state and next-output logic for the APB transfer FSM
    always_comb begin
        state_d     = state_q;
        prdata_d    = prdata_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        req_valid_d = req_valid_q;
        req_d       = req_q;
        wd_valid_d  = wd_valid_q;
        wd_data_d   = wd_data_q;
        rd_ready_d  = 1'b0;
        addr_d      = addr_q;
        ctrl_d      = ctrl_q;
        err_count_d = err_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d  = ST_ACCESS;
                    pready_d = 1'b1;
                    if (!acc_ok) begin
                        // Decode error: complete with no side effect
                        pslverr_d = 1'b1;
                        if (!PWRITE) begin
                            prdata_d = '0;
                        end
                    end else begin
                        case (reg_sel)
                            SEL_ADDR: begin
                                if (PWRITE) addr_d = AXI_ADDR_WIDTH'(PWDATA);
                                else        prdata_d = DATA_WIDTH'(addr_q);
                            end
                            SEL_CTRL: begin
                                if (PWRITE) ctrl_d = ctrl_reg_t'(PWDATA[11:0]);
                                else        prdata_d = DATA_WIDTH'(ctrl_q);
                            end
                            SEL_CMD: begin
                                req_d.addr  = REQ_ADDR_W'(addr_q);
                                req_d.len   = ctrl_q.len;
                                req_d.size  = ctrl_q.size;
                                req_d.write = ctrl_q.write;
                                req_d.tag   = PWDATA[3:0];
                                req_valid_d = 1'b1;
                                pready_d    = 1'b0;
                                state_d     = ST_WAIT_REQ;
                            end
                            SEL_WDATA: begin
                                wd_data_d  = PWDATA;
                                wd_valid_d = 1'b1;
                                pready_d   = 1'b0;
                                state_d    = ST_WAIT_WD;
                            end
                            SEL_RDATA: begin
                                pready_d = 1'b0;
                                state_d  = ST_WAIT_RD;
                            end
                            SEL_STATUS: begin
                                prdata_d = DATA_WIDTH'(status_word(req_valid_q, rd_valid,
                                                                   wd_valid_q, err_count_q));
                            end
                            default: begin
                                pslverr_d = 1'b1;
                            end
                        endcase
                    end
                end
            end

            ST_WAIT_REQ: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    pready_d    = 1'b1;
                    state_d     = ST_DONE;
                end else if (tmo_expired) begin
                    req_valid_d = 1'b0;
                    pready_d    = 1'b1;
                    pslverr_d   = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_WAIT_WD: begin
                if (wd_ready) begin
                    wd_valid_d = 1'b0;
                    pready_d   = 1'b1;
                    state_d    = ST_DONE;
                end else if (tmo_expired) begin
                    wd_valid_d = 1'b0;
                    pready_d   = 1'b1;
                    pslverr_d  = 1'b1;
                    state_d    = ST_DONE;
                end
            end

            ST_WAIT_RD: begin
                if (rd_valid) begin
                    rd_ready_d = 1'b1;
                    prdata_d   = rd_data;
                    pslverr_d  = rd_err;
                    pready_d   = 1'b1;
                    state_d    = ST_DONE;
                end else if (tmo_expired) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end

            ST_ACCESS, ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every completion carrying PSLVERR bumps the saturating error counter
        if (pready_d && pslverr_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and registered outputs; reset overrides any transfer in flight
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
            wd_valid_q  <= 1'b0;
            wd_data_q   <= '0;
            rd_ready_q  <= 1'b0;
            addr_q      <= '0;
            ctrl_q      <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
            wd_valid_q  <= wd_valid_d;
            wd_data_q   <= wd_data_d;
            rd_ready_q  <= rd_ready_d;
            addr_q      <= addr_d;
            ctrl_q      <= ctrl_d;
            err_count_q <= err_count_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign req_valid = req_valid_q;
    assign req_addr  = AXI_ADDR_WIDTH'(req_q.addr);
    assign req_len   = req_q.len;
    assign req_size  = req_q.size;
    assign req_write = req_q.write;
    assign req_tag   = req_q.tag;
    assign wd_valid  = wd_valid_q;
    assign wd_data   = wd_data_q;
    assign rd_ready  = rd_ready_q;

endmodule

// File: tb/tb_apb2axi_apb_frontend.sv
// Scoreboard bench for the APB front-end: stimulus queues expected APB
// completions, descriptors and beats; monitors pop and compare.
module tb_apb2axi_apb_frontend;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic        req_write;
    logic [3:0]  req_tag;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_err;

    typedef struct {
        logic        chk_data;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } apb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        wr;
        logic [3:0]  tag;
    } req_exp_t;

    apb_exp_t    apb_q[$];
    req_exp_t    req_q[$];
    logic [31:0] wd_q[$];

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int p0;

    always #5 PCLK = ~PCLK;

    apb2axi_apb_frontend #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYC(256)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .req_write (req_write),
        .req_tag   (req_tag),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_err    (rd_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // APB completion monitor: counts wait states and pops one expectation per PREADY
    initial begin
        int waits = 0;
        apb_exp_t e;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                waits = 0;
            end else if (PSEL && PENABLE) begin
                if (!PREADY) begin
                    waits++;
                end else begin
                    if (apb_q.size() == 0) begin
                        chk("apb_unexpected", 32'(PREADY), 32'd0);
                    end else begin
                        e = apb_q.pop_front();
                        chk("apb_pslverr", 32'(PSLVERR), 32'(e.err));
                        chk("apb_waits", 32'(waits), 32'(e.waits));
                        if (e.chk_data) chk("apb_prdata", PRDATA, e.rdata);
                    end
                    waits = 0;
                end
            end
        end
    end

    // Descriptor monitor: payload must match (and stay stable) while valid
    initial begin
        forever begin
            @(negedge PCLK);
            if (!PRESET && req_valid) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 32'(req_valid), 32'd0);
                end else begin
                    chk("req_addr", req_addr, req_q[0].addr);
                    chk("req_len", 32'(req_len), 32'(req_q[0].len));
                    chk("req_size", 32'(req_size), 32'(req_q[0].size));
                    chk("req_write", 32'(req_write), 32'(req_q[0].wr));
                    chk("req_tag", 32'(req_tag), 32'(req_q[0].tag));
                    if (req_ready) void'(req_q.pop_front());
                end
            end
        end
    end

    // Write-beat monitor and rd_ready pulse counter
    initial begin
        forever begin
            @(negedge PCLK);
            if (!PRESET && rd_ready) rd_pulses++;
            if (!PRESET && wd_valid) begin
                if (wd_q.size() == 0) begin
                    chk("wd_unexpected", 32'(wd_valid), 32'd0);
                end else begin
                    chk("wd_data", wd_data, wd_q[0]);
                    if (wd_ready) void'(wd_q.pop_front());
                end
            end
        end
    end

    // One APB transfer starting at posedge+1; ends at posedge+1 after PREADY
    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic chk_data, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_waits);
        apb_exp_t e;
        logic done;
        e.chk_data = chk_data;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        e.waits    = exp_waits;
        apb_q.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge PCLK);
            if (PREADY) done = 1'b1;
        end
        if (!done) chk("apb_timeout_bound", 32'(done), 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Bridge-core read beat: presented after 'delay' cycles, held until rd_ready
    task automatic rd_beat(input int delay, input logic [31:0] d, input logic e);
        logic seen;
        repeat (delay) @(posedge PCLK);
        #1;
        rd_valid = 1'b1; rd_data = d; rd_err = e;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge PCLK);
            if (rd_ready) seen = 1'b1;
        end
        @(posedge PCLK); #1;
        rd_valid = 1'b0; rd_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1; PADDR = '0; PWRITE = 1'b0; PWDATA = '0; PSEL = 1'b0; PENABLE = 1'b0;
        req_ready = 1'b1; wd_ready = 1'b1; rd_valid = 1'b0; rd_data = '0; rd_err = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_wd_valid", 32'(wd_valid), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Plain registers: zero wait states, back-to-back
        apb_xfer(1'b1, 32'h00, 32'h8000_1000, 1'b0, 32'h0, 1'b0, 0);
        apb_xfer(1'b1, 32'h04, 32'h0000_080F, 1'b0, 32'h0, 1'b0, 0);
        apb_xfer(1'b0, 32'h00, 32'h0, 1'b1, 32'h8000_1000, 1'b0, 0);
        apb_xfer(1'b0, 32'h04, 32'h0, 1'b1, 32'h0000_080F, 1'b0, 0);

        // CMD: req_ready low for setup + 2 wait cycles, high on the 3rd wait cycle
        req_ready = 1'b0;
        req_q.push_back('{addr: 32'h8000_1000, len: 8'd15, size: 3'd0, wr: 1'b1, tag: 4'h5});
        fork
            apb_xfer(1'b1, 32'h08, 32'h0000_0005, 1'b0, 32'h0, 1'b0, 3);
            begin
                repeat (3) @(posedge PCLK);
                #1 req_ready = 1'b1;
            end
        join
        req_ready = 1'b1;

        // WDATA with wd_ready already high: one wait state
        wd_q.push_back(32'h1234_5678);
        apb_xfer(1'b1, 32'h0C, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1);

        // RDATA, beat appears 10 cycles after setup
        p0 = rd_pulses;
        fork
            apb_xfer(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 10);
            rd_beat(10, 32'hDEAD_BEEF, 1'b0);
        join
        chk("rd_ready_pulses", 32'(rd_pulses - p0), 32'd1);

        // RDATA with AXI error
        p0 = rd_pulses;
        fork
            apb_xfer(1'b0, 32'h10, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1, 10);
            rd_beat(10, 32'h0BAD_F00D, 1'b1);
        join
        chk("rd_ready_pulses_err", 32'(rd_pulses - p0), 32'd1);
        apb_xfer(1'b0, 32'h14, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 0);

        // RDATA timeout: 256 wait states then error, no rd_ready
        p0 = rd_pulses;
        apb_xfer(1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1, 256);
        chk("rd_ready_pulses_tmo", 32'(rd_pulses - p0), 32'd0);
        apb_xfer(1'b0, 32'h14, 32'h0, 1'b1, 32'h0000_0200, 1'b0, 0);

        // Decode errors: unmapped write, read of WO, write of RO
        apb_xfer(1'b1, 32'h1C, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 0);
        apb_xfer(1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 1'b1, 0);
        apb_xfer(1'b1, 32'h14, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 0);
        apb_xfer(1'b0, 32'h00, 32'h0, 1'b1, 32'h8000_1000, 1'b0, 0);
        apb_xfer(1'b0, 32'h14, 32'h0, 1'b1, 32'h0000_0500, 1'b0, 0);

        // Reset while waiting on a write beat
        wd_ready = 1'b0;
        wd_q.push_back(32'hCAFE_0001);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0C; PWRITE = 1'b1; PWDATA = 32'hCAFE_0001;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        wd_q.delete();
        @(negedge PCLK);
        chk("wd_rst_wd_valid", 32'(wd_valid), 32'd0);
        chk("wd_rst_pready", 32'(PREADY), 32'd0);
        chk("wd_rst_pslverr", 32'(PSLVERR), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        wd_ready = 1'b1;
        apb_xfer(1'b0, 32'h00, 32'h0, 1'b1, 32'h0, 1'b0, 0);
        apb_xfer(1'b0, 32'h04, 32'h0, 1'b1, 32'h0, 1'b0, 0);
        apb_xfer(1'b0, 32'h14, 32'h0, 1'b1, 32'h0, 1'b0, 0);

        repeat (3) @(posedge PCLK);
        chk("apb_q_drained", 32'(apb_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("wd_q_drained", 32'(wd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
